// File: rtl/datapath_pkg.sv
// Shared constants for the datapath: opcodes, IR field positions, memory size, CON conditions.
// DATAPATH_MUL_EN enables the signed multiply opcode in datapath_alu.
package datapath_pkg;

  localparam int W         = 32;
  localparam int MEM_DEPTH = 512;
  localparam int MEM_AW    = 9;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;
  localparam int C_HI  = 18;
  localparam int C2_HI = 20;
  localparam int C2_LO = 19;

  typedef enum logic [4:0] {
    OP_LD   = 5'b00000,
    OP_LDI  = 5'b00001,
    OP_ST   = 5'b00010,
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_SHR  = 5'b00111,
    OP_SHL  = 5'b01000,
    OP_ADDI = 5'b01011,
    OP_ANDI = 5'b01100,
    OP_ORI  = 5'b01101,
    OP_MUL  = 5'b01110,
    OP_NEG  = 5'b10000,
    OP_NOT  = 5'b10001,
    OP_BR   = 5'b10010
  } opcode_e;

  typedef enum logic [1:0] {
    C2_ZERO = 2'b00,
    C2_NZ   = 2'b01,
    C2_POS  = 2'b10,
    C2_NEG  = 2'b11
  } cond_e;

  function automatic logic [W-1:0] sext_c(input logic [C_HI:0] c);
    return {{(W-C_HI-1){c[C_HI]}}, c};
  endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A = Y, B = bus; IncPC forces bus+1.
// DATAPATH_MUL_EN: opcode 01110 yields the signed 64-bit product, else it adds.
module datapath_alu
  import datapath_pkg::*;
(
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [4:0]     opcode,
  input  logic           IncPC,
  output logic [2*W-1:0] result
);

  logic [W-1:0] w_lo;

`ifdef DATAPATH_MUL_EN
  logic signed [2*W-1:0] w_prod;
  assign w_prod = $signed(A) * $signed(B);
`endif

  always_comb begin
    w_lo   = A + B;
    result = '0;
    case (opcode)
      OP_SUB:          w_lo = A - B;
      OP_AND, OP_ANDI: w_lo = A & B;
      OP_OR, OP_ORI:   w_lo = A | B;
      OP_SHR:          w_lo = A >> B[4:0];
      OP_SHL:          w_lo = A << B[4:0];
      OP_NEG:          w_lo = -B;
      OP_NOT:          w_lo = ~B;
      default:         w_lo = A + B;
    endcase
    result = {{W{1'b0}}, w_lo};
`ifdef DATAPATH_MUL_EN
    if (opcode == OP_MUL) result = w_prod;
`endif
    // PC increment ignores whatever opcode IR holds
    if (IncPC) result = {{W{1'b0}}, B + 32'd1};
  end

endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit datapath: register file, PC/IR/MAR/MDR/Y/Z, CON flag, 512-word memory.
// DATAPATH_MUL_EN adds the signed multiply opcode (see datapath_alu).
module datapath
  import datapath_pkg::*;
(
  input  logic         Clock,
  input  logic         Clear,
  input  logic         PCout,
  input  logic         Zlowout,
  input  logic         Zhighout,
  input  logic         MDRout,
  input  logic         Cout,
  input  logic         Rout,
  input  logic         BAout,
  input  logic         MARin,
  input  logic         Zin,
  input  logic         PCin,
  input  logic         MDRin,
  input  logic         IRin,
  input  logic         Yin,
  input  logic         Rin,
  input  logic         CONin,
  input  logic         IncPC,
  input  logic         Read,
  input  logic         Write,
  input  logic         Gra,
  input  logic         Grb,
  input  logic         Grc,
  output logic [31:0]  Busout,
  output logic [31:0]  Z_low,
  output logic [31:0]  Z_high,
  output logic [31:0]  R1out,
  output logic [31:0]  R0out
);

  logic [W-1:0]   r_reg [16];
  logic [W-1:0]   r_pc;
  logic [W-1:0]   r_ir;
  logic [W-1:0]   r_mar;
  logic [W-1:0]   r_mdr;
  logic [W-1:0]   r_y;
  logic [2*W-1:0] r_z;
  logic           r_con;
  logic [W-1:0]   r_mem [MEM_DEPTH];

  logic [3:0]        w_sel;
  logic [W-1:0]      w_sel_val;
  logic [W-1:0]      w_c;
  logic [W-1:0]      w_bus;
  logic [W-1:0]      w_mem_rd;
  logic [MEM_AW-1:0] w_addr;
  logic [2*W-1:0]    w_alu;
  logic              w_con_nxt;
  logic              w_unused;

  assign w_sel = ({4{Gra}} & r_ir[RA_HI:RA_LO])
               | ({4{Grb}} & r_ir[RB_HI:RB_LO])
               | ({4{Grc}} & r_ir[RC_HI:RC_LO]);

  assign w_sel_val = r_reg[w_sel];
  assign w_c       = sext_c(r_ir[C_HI:0]);
  assign w_addr    = r_mar[MEM_AW-1:0];
  assign w_mem_rd  = r_mem[w_addr];
  assign w_unused  = &{1'b0, r_mar[W-1:MEM_AW]};

  always_comb begin
    w_bus = '0;
    priority case (1'b1)
      Zhighout: w_bus = r_z[2*W-1:W];
      Zlowout:  w_bus = r_z[W-1:0];
      PCout:    w_bus = r_pc;
      MDRout:   w_bus = r_mdr;
      Cout:     w_bus = w_c;
      Rout:     w_bus = w_sel_val;
      // base-address form: R0 reads as zero
      BAout:    w_bus = (w_sel == 4'd0) ? '0 : w_sel_val;
      default:  w_bus = '0;
    endcase
  end

  always_comb begin
    w_con_nxt = 1'b0;
    unique case (cond_e'(r_ir[C2_HI:C2_LO]))
      C2_ZERO: w_con_nxt = (w_bus == '0);
      C2_NZ:   w_con_nxt = (w_bus != '0);
      C2_POS:  w_con_nxt = ~w_bus[W-1];
      C2_NEG:  w_con_nxt = w_bus[W-1];
      default: w_con_nxt = 1'b0;
    endcase
  end

  datapath_alu u_alu (
    .A      (r_y),
    .B      (w_bus),
    .opcode (r_ir[OP_HI:OP_LO]),
    .IncPC  (IncPC),
    .result (w_alu)
  );

  always_ff @(posedge Clock) begin
    if (Clear) begin
      for (int i = 0; i < 16; i++) r_reg[i] <= '0;
      r_pc  <= '0;
      r_ir  <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_y   <= '0;
      r_z   <= '0;
      r_con <= 1'b0;
    end else begin
      if (Rin)   r_reg[w_sel] <= w_bus;
      if (PCin)  r_pc  <= w_bus;
      if (IRin)  r_ir  <= w_bus;
      if (MARin) r_mar <= w_bus;
      if (Yin)   r_y   <= w_bus;
      if (Zin)   r_z   <= w_alu;
      if (CONin) r_con <= w_con_nxt;
      if (MDRin) r_mdr <= Read ? w_mem_rd : w_bus;
    end
  end

  // memory survives Clear, but a write in the Clear cycle is dropped
  always_ff @(posedge Clock) begin
    if (Write && !Clear) r_mem[w_addr] <= r_mdr;
  end

  assign Busout = w_bus;
  assign Z_low  = r_z[W-1:0];
  assign Z_high = r_z[2*W-1:W];
  assign R0out  = r_reg[0];
  assign R1out  = r_reg[1];

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed fetch/store/CON/MUL sequences, then random control
// words, all checked every cycle against a behavioural model of the machine.
module tb_datapath;

  typedef logic [21:0] ctrl_t;

  localparam ctrl_t CLR  = 22'h000001;
  localparam ctrl_t PCO  = 22'h000002;
  localparam ctrl_t ZLO  = 22'h000004;
  localparam ctrl_t ZHO  = 22'h000008;
  localparam ctrl_t MDRO = 22'h000010;
  localparam ctrl_t CO   = 22'h000020;
  localparam ctrl_t RO   = 22'h000040;
  localparam ctrl_t BAO  = 22'h000080;
  localparam ctrl_t MARI = 22'h000100;
  localparam ctrl_t ZI   = 22'h000200;
  localparam ctrl_t PCI  = 22'h000400;
  localparam ctrl_t MDRI = 22'h000800;
  localparam ctrl_t IRI  = 22'h001000;
  localparam ctrl_t YI   = 22'h002000;
  localparam ctrl_t RI   = 22'h004000;
  localparam ctrl_t CONI = 22'h008000;
  localparam ctrl_t INC  = 22'h010000;
  localparam ctrl_t RD   = 22'h020000;
  localparam ctrl_t WR   = 22'h040000;
  localparam ctrl_t GRA  = 22'h080000;
  localparam ctrl_t GRB  = 22'h100000;
  localparam ctrl_t GRC  = 22'h200000;
  localparam ctrl_t IDLE = 22'h000000;

  logic        Clock = 1'b0;
  ctrl_t       c = '0;
  logic [31:0] Busout, Z_low, Z_high, R1out, R0out;

  datapath dut (
    .Clock    (Clock),
    .Clear    (|(c & CLR)),
    .PCout    (|(c & PCO)),
    .Zlowout  (|(c & ZLO)),
    .Zhighout (|(c & ZHO)),
    .MDRout   (|(c & MDRO)),
    .Cout     (|(c & CO)),
    .Rout     (|(c & RO)),
    .BAout    (|(c & BAO)),
    .MARin    (|(c & MARI)),
    .Zin      (|(c & ZI)),
    .PCin     (|(c & PCI)),
    .MDRin    (|(c & MDRI)),
    .IRin     (|(c & IRI)),
    .Yin      (|(c & YI)),
    .Rin      (|(c & RI)),
    .CONin    (|(c & CONI)),
    .IncPC    (|(c & INC)),
    .Read     (|(c & RD)),
    .Write    (|(c & WR)),
    .Gra      (|(c & GRA)),
    .Grb      (|(c & GRB)),
    .Grc      (|(c & GRC)),
    .Busout   (Busout),
    .Z_low    (Z_low),
    .Z_high   (Z_high),
    .R1out    (R1out),
    .R0out    (R0out)
  );

  always #5 Clock = ~Clock;

  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y;
  logic [63:0] m_z;
  logic        m_con;
  logic [31:0] m_mem [512];
  logic [31:0] last_bus;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic on(input ctrl_t k, input ctrl_t m);
    return |(k & m);
  endfunction

  function automatic logic [3:0] m_sel(input ctrl_t k);
    logic [3:0] s;
    s = 4'h0;
    if (on(k, GRA)) s = s | m_ir[26:23];
    if (on(k, GRB)) s = s | m_ir[22:19];
    if (on(k, GRC)) s = s | m_ir[18:15];
    return s;
  endfunction

  function automatic logic [31:0] m_bus(input ctrl_t k);
    if (on(k, ZHO))  return m_z[63:32];
    if (on(k, ZLO))  return m_z[31:0];
    if (on(k, PCO))  return m_pc;
    if (on(k, MDRO)) return m_mdr;
    if (on(k, CO))   return 32'(int'($signed(m_ir[18:0])));
    if (on(k, RO))   return m_r[m_sel(k)];
    if (on(k, BAO))  return (m_sel(k) == 4'h0) ? 32'h0 : m_r[m_sel(k)];
    return 32'h0;
  endfunction

  function automatic logic [63:0] m_alu(input int op, input logic [31:0] a,
                                        input logic [31:0] b, input logic inc);
    logic [31:0] r;
    if (inc) return {32'h0, b + 32'h1};
    case (op)
      4:       r = a - b;
      5, 12:   r = a & b;
      6, 13:   r = a | b;
      7:       r = a >> b[4:0];
      8:       r = a << b[4:0];
      16:      r = 32'h0 - b;
      17:      r = ~b;
`ifdef DATAPATH_MUL_EN
      14:      return 64'(longint'($signed(a)) * longint'($signed(b)));
`endif
      default: r = a + b;
    endcase
    return {32'h0, r};
  endfunction

  function automatic logic m_cond(input logic [31:0] b);
    case (m_ir[20:19])
      2'b00:   return b == 32'h0;
      2'b01:   return b != 32'h0;
      2'b10:   return !b[31];
      default: return b[31];
    endcase
  endfunction

  task automatic cycle(input ctrl_t k);
    logic [31:0] b, old_w, old_mdr;
    logic [8:0]  a;
    logic [63:0] alu;
    logic [3:0]  s;
    logic        cn;
    @(negedge Clock);
    c = k;
    #1;
    b       = m_bus(k);
    s       = m_sel(k);
    a       = m_mar[8:0];
    old_w   = m_mem[a];
    old_mdr = m_mdr;
    alu     = m_alu(int'(m_ir[31:27]), m_y, b, on(k, INC));
    cn      = m_cond(b);
    last_bus = Busout;
    chk("bus", {32'h0, Busout}, {32'h0, b});
    @(posedge Clock);
    if (on(k, CLR)) begin
      for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
      m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_y = 0;
      m_z = 0; m_con = 0;
    end else begin
      if (on(k, WR))   m_mem[a] = old_mdr;
      if (on(k, MDRI)) m_mdr = on(k, RD) ? old_w : b;
      if (on(k, RI))   m_r[s] = b;
      if (on(k, PCI))  m_pc = b;
      if (on(k, IRI))  m_ir = b;
      if (on(k, MARI)) m_mar = b;
      if (on(k, YI))   m_y = b;
      if (on(k, ZI))   m_z = alu;
      if (on(k, CONI)) m_con = cn;
    end
    #1;
    chk("z_low", {32'h0, Z_low}, {32'h0, m_z[31:0]});
    chk("z_high", {32'h0, Z_high}, {32'h0, m_z[63:32]});
    chk("r0", {32'h0, R0out}, {32'h0, m_r[0]});
    chk("r1", {32'h0, R1out}, {32'h0, m_r[1]});
    chk("con", {63'h0, dut.r_con}, {63'h0, m_con});
  endtask

  // builds v in Z_low by doubling and incrementing; needs an add-class opcode in IR
  task automatic load_const(input logic [31:0] v);
    cycle(YI);
    cycle(ZI);
    for (int i = 31; i >= 0; i--) begin
      cycle(ZLO | YI);
      cycle(ZLO | ZI);
      if (v[i]) cycle(ZLO | INC | ZI);
    end
  endtask

  initial begin
    ctrl_t k;
    for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
    for (int i = 0; i < 512; i++) m_mem[i] = 32'h0;
    m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_y = 0; m_z = 0; m_con = 0;

    cycle(CLR);
    chk("rst_zl", {32'h0, Z_low}, 64'h0);
    chk("rst_zh", {32'h0, Z_high}, 64'h0);
    chk("rst_r0", {32'h0, R0out}, 64'h0);
    chk("rst_r1", {32'h0, R1out}, 64'h0);
    cycle(IDLE);
    chk("rst_bus", {32'h0, last_bus}, 64'h0);

    for (int i = 0; i < 512; i++) begin
      cycle(ZLO | MARI);
      cycle(WR | ZLO | INC | ZI);
    end

    load_const(32'h10800067);
    cycle(ZLO | MDRI);
    cycle(MARI);
    cycle(WR);
    load_const(32'd5);
    cycle(ZLO | GRA | RI);
    load_const(32'h00800000);
    cycle(ZLO | IRI);
    load_const(32'h34);
    cycle(ZLO | GRA | RI);
    chk("r0_init", {32'h0, R0out}, 64'd5);
    chk("r1_init", {32'h0, R1out}, 64'h34);

    cycle(PCO | MARI | INC | ZI);
    chk("T0_zlow", {32'h0, Z_low}, 64'd1);
    cycle(ZLO | PCI | RD | MDRI);
    cycle(MDRO | IRI);
    chk("T2_ir_bus", {32'h0, last_bus}, 64'h10800067);
    cycle(PCO);
    chk("T1_pc", {32'h0, last_bus}, 64'd1);
    cycle(GRB | BAO | YI);
    chk("T3_ba_r0", {32'h0, last_bus}, 64'h0);
    cycle(CO | ZI);
    chk("T4_zlow", {32'h0, Z_low}, 64'h67);
    cycle(ZLO | MARI);
    cycle(GRA | BAO | MDRI);
    chk("T6_bus", {32'h0, last_bus}, 64'h34);
    cycle(WR);
    cycle(MDRI);
    cycle(MDRO);
    chk("mdr_zero", {32'h0, last_bus}, 64'h0);
    cycle(RD | MDRI);
    cycle(MDRO);
    chk("T7_mem", {32'h0, last_bus}, 64'h34);
    chk("T7_r1", {32'h0, R1out}, 64'h34);

    cycle(PCO | MDRI);
    cycle(RD | WR | MDRI);
    cycle(MDRO);
    chk("rw_old", {32'h0, last_bus}, 64'h34);
    cycle(RD | MDRI);
    cycle(MDRO);
    chk("rw_new", {32'h0, last_bus}, 64'd1);

    cycle(ZLO | MDRI);
    cycle(CLR | WR | ZLO | INC | ZI | GRA | RI);
    chk("clr_zl", {32'h0, Z_low}, 64'h0);
    chk("clr_r1", {32'h0, R1out}, 64'h0);
    load_const(32'h67);
    cycle(ZLO | MARI);
    cycle(RD | MDRI);
    cycle(MDRO);
    chk("clr_nowr", {32'h0, last_bus}, 64'd1);

    load_const(32'h001FFFFF);
    cycle(ZLO | IRI);
    cycle(CO);
    chk("c_sext", {32'h0, last_bus}, 64'hFFFFFFFF);
    cycle(CO | CONI);
    chk("con_neg", {63'h0, dut.r_con}, 64'd1);

    load_const(32'd4);
    cycle(ZLO | GRA | RI);
    load_const(32'h7007FFFD);
    cycle(ZLO | IRI);
    cycle(CO | YI);
    cycle(GRA | RO | ZI);
`ifdef DATAPATH_MUL_EN
    chk("mul_hi", {32'h0, Z_high}, 64'hFFFFFFFF);
    chk("mul_lo", {32'h0, Z_low}, 64'hFFFFFFF4);
`else
    chk("mul_hi", {32'h0, Z_high}, 64'h0);
    chk("mul_lo", {32'h0, Z_low}, 64'd1);
`endif

    for (int n = 0; n < 2500; n++) begin
      k = ctrl_t'($urandom) & ctrl_t'($urandom) & ~CLR;
      if ($urandom_range(63) == 0) k = k | CLR;
      cycle(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
